// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO and serialises
// each word as start, DATAW data bits LSB first, and one stop bit.
module fifo_uart_tx #(
  parameter int DATAW        = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DATAW-1:0] i_rd_data,
  input  logic             i_rd_empty,
  output logic             o_rd_en,
  output logic             o_tx,
  output logic             o_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATAW + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATAW - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cyc_cnt_r, cyc_cnt_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [DATAW-1:0] shift_r, shift_s;
  logic             tx_r, tx_s;
  logic             busy_r, busy_s;
  logic             load_s;
  logic             bit_last_s;

  assign bit_last_s = (cyc_cnt_r == CYC_LAST);
  assign o_rd_en    = load_s;
  assign o_tx       = tx_r;
  assign o_busy     = busy_r;

  // State, counters, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cyc_cnt_r <= '0;
      bit_cnt_r <= '0;
      shift_r   <= '0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cyc_cnt_r <= cyc_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
    end
  end

  // Next-state, counter and pop-strobe logic; line level is derived from the next state.
  always_comb begin
    state_s   = state_r;
    cyc_cnt_s = cyc_cnt_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    load_s    = 1'b0;
    tx_s      = 1'b1;
    busy_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cyc_cnt_s = '0;
        if (!i_rd_empty) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_START: begin
        if (bit_last_s) begin
          state_s   = ST_DATA;
          cyc_cnt_s = '0;
        end else begin
          cyc_cnt_s = cyc_cnt_r + CYC_ONE;
        end
      end
      ST_DATA: begin
        if (bit_last_s) begin
          cyc_cnt_s = '0;
          shift_s   = {1'b0, shift_r[DATAW-1:1]};
          bit_cnt_s = bit_cnt_r + BIT_ONE;
          if (bit_cnt_r == BIT_LAST) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          cyc_cnt_s = cyc_cnt_r + CYC_ONE;
        end
      end
      ST_STOP: begin
        if (bit_last_s) begin
          cyc_cnt_s = '0;
          if (!i_rd_empty) begin
            load_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cyc_cnt_s = cyc_cnt_r + CYC_ONE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        cyc_cnt_s = '0;
      end
    endcase

    // A pop at the end of STOP chains straight into the next START with no gap.
    if (load_s) begin
      state_s   = ST_START;
      shift_s   = i_rd_data;
      cyc_cnt_s = '0;
      bit_cnt_s = '0;
    end else begin
      shift_s   = shift_s;
    end

    case (state_s)
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = shift_s[0];
      ST_STOP:  tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase

    if (state_s != ST_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed plus randomized bench for fifo_uart_tx with a 4-deep FWFT FIFO model
// and a mid-bit sampling serial-line decoder as the reference.
module tb_fifo_uart_tx;

  localparam int DATAW = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = (DATAW + 2) * CPB;

  logic             clk;
  logic             rst_n;
  logic [DATAW-1:0] i_rd_data;
  logic             i_rd_empty;
  logic             o_rd_en;
  logic             o_tx;
  logic             o_busy;

  fifo_uart_tx #(.DATAW(DATAW), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_data (i_rd_data),
    .i_rd_empty(i_rd_empty),
    .o_rd_en   (o_rd_en),
    .o_tx      (o_tx),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pop_err  = 0;
  int frame_err = 0;
  int fill_max = 0;
  bit gaps     = 1'b0;

  logic [7:0] fifo_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] dec_q[$];
  logic [7:0] sent_q[$];
  logic       tx_tr[$];
  logic       busy_tr[$];
  logic       ren_tr[$];

  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  logic       prev_tx = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level i cycles into a frame carrying b.
  function automatic logic exp_level(input logic [7:0] b, input int i);
    int j;
    j = i / CPB;
    if (j == 0) return 1'b0;
    else if (j <= DATAW) return b[j-1];
    else return 1'b1;
  endfunction

  function automatic int first_pop();
    for (int k = 0; k < ren_tr.size(); k++) if (ren_tr[k]) return k;
    return -1;
  endfunction

  task automatic clear_traces();
    tx_tr.delete(); busy_tr.delete(); ren_tr.delete(); dec_q.delete();
    pop_err = 0; frame_err = 0; fill_max = 0;
  endtask

  task automatic update_fifo_ports();
    i_rd_empty = (fifo_q.size() == 0);
    i_rd_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  // One clock: sample on negedge (trace + line decoder), then model the FIFO after posedge.
  task automatic tick();
    logic ren;
    @(negedge clk);
    ren = o_rd_en;
    if (o_rd_en && i_rd_empty) pop_err++;
    tx_tr.push_back(o_tx);
    busy_tr.push_back(o_busy);
    ren_tr.push_back(o_rd_en);
    if (!mon_act) begin
      if (prev_tx && !o_tx) begin
        mon_act = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= CPB + 2 && mon_cnt <= DATAW * CPB + 2 && ((mon_cnt - CPB - 2) % CPB) == 0)
        mon_byte[(mon_cnt - CPB - 2) / CPB] = o_tx;
      if (mon_cnt == (DATAW + 1) * CPB + 2) begin
        if (!o_tx) frame_err++;
        dec_q.push_back(mon_byte);
        mon_act = 1'b0;
      end
    end
    prev_tx = o_tx;
    @(posedge clk);
    #1;
    if (ren && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (wr_q.size() > 0 && fifo_q.size() < DEPTH && (!gaps || $urandom_range(0, 2) != 0))
      fifo_q.push_back(wr_q.pop_front());
    if (fifo_q.size() > fill_max) fill_max = fifo_q.size();
    update_fifo_ports();
  endtask

  initial begin
    int p, cnt, mism;
    bit got;
    logic [7:0] exp3[3];
    logic [7:0] exp4[5];

    rst_n = 1'b0;
    update_fifo_ports();
    #23;
    chk("reset_tx", o_tx, 1'b1);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_rd_en", o_rd_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with an empty FIFO.
    clear_traces();
    repeat (100) tick();
    cnt = 0; mism = 0;
    for (int k = 0; k < 100; k++) begin
      cnt += ren_tr[k];
      if (tx_tr[k] !== 1'b1 || busy_tr[k] !== 1'b0) mism++;
    end
    chk("idle_pops", cnt, 0);
    chk("idle_line", mism, 0);

    // Single 0xA5 frame.
    clear_traces();
    wr_q.push_back(8'hA5);
    repeat (60) tick();
    p = first_pop();
    chk("a5_pop_found", (p >= 0), 1'b1);
    if (p >= 0) begin
      cnt = 0; mism = 0;
      for (int k = 0; k < ren_tr.size(); k++) cnt += ren_tr[k];
      chk("a5_pop_count", cnt, 1);
      chk("a5_busy_before", busy_tr[p], 1'b0);
      for (int i = 0; i < FRAME; i++)
        if (tx_tr[p+1+i] !== exp_level(8'hA5, i) || busy_tr[p+1+i] !== 1'b1) mism++;
      chk("a5_wave", mism, 0);
      chk("a5_tx_after", tx_tr[p+1+FRAME], 1'b1);
      chk("a5_busy_after", busy_tr[p+1+FRAME], 1'b0);
    end

    // Three back-to-back frames.
    clear_traces();
    exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h3C;
    for (int k = 0; k < 3; k++) wr_q.push_back(exp3[k]);
    repeat (140) tick();
    p = first_pop();
    chk("b2b_pop_found", (p >= 0), 1'b1);
    if (p >= 0) begin
      cnt = 0; mism = 0;
      for (int k = 0; k < ren_tr.size(); k++) cnt += ren_tr[k];
      chk("b2b_pop_count", cnt, 3);
      for (int i = 0; i < 3 * FRAME; i++)
        if (tx_tr[p+1+i] !== exp_level(exp3[i / FRAME], i % FRAME) || busy_tr[p+1+i] !== 1'b1) mism++;
      chk("b2b_wave", mism, 0);
      chk("b2b_busy_after", busy_tr[p+1+3*FRAME], 1'b0);
      chk("b2b_fifo_empty", i_rd_empty, 1'b1);
      chk("b2b_pop_when_empty", pop_err, 0);
    end

    // Fill the FIFO to full while a frame is in flight.
    clear_traces();
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44; exp4[4] = 8'h66;
    wr_q.push_back(exp4[0]);
    repeat (8) tick();
    for (int k = 1; k < 5; k++) wr_q.push_back(exp4[k]);
    for (int k = 0; k < 400 && dec_q.size() < 5; k++) tick();
    chk("full_fill_max", fill_max, DEPTH);
    chk("full_decoded_count", dec_q.size(), 5);
    for (int k = 0; k < 5 && k < dec_q.size(); k++) chk("full_order", dec_q[k], exp4[k]);
    chk("full_pop_when_empty", pop_err, 0);
    chk("full_frame_err", frame_err, 0);

    // Reset in the middle of data bit 3 of 0x55.
    clear_traces();
    wr_q.push_back(8'h55);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = ren_tr[ren_tr.size()-1];
    end
    chk("rst_pop_found", got, 1'b1);
    repeat (18) tick();
    chk("rst_pre_bit3", o_tx, 1'b0);
    chk("rst_pre_busy", o_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", o_tx, 1'b1);
    chk("rst_mid_busy", o_busy, 1'b0);
    chk("rst_mid_rd_en", o_rd_en, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_act = 1'b0;
    prev_tx = 1'b1;
    dec_q.delete();
    wr_q.push_back(8'hC3);
    for (int k = 0; k < 100 && dec_q.size() < 1; k++) tick();
    repeat (20) tick();
    chk("rst_after_count", dec_q.size(), 1);
    if (dec_q.size() > 0) chk("rst_after_word", dec_q[0], 8'hC3);
    chk("rst_frame_err", frame_err, 0);

    // 256 random bytes written with random gaps.
    clear_traces();
    gaps = 1'b1;
    sent_q.delete();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      sent_q.push_back(b);
      wr_q.push_back(b);
    end
    for (int k = 0; k < 30000 && dec_q.size() < 256; k++) tick();
    chk("rand_count", dec_q.size(), 256);
    for (int k = 0; k < 256 && k < dec_q.size(); k++) chk("rand_byte", dec_q[k], sent_q[k]);
    chk("rand_pop_when_empty", pop_err, 0);
    chk("rand_frame_err", frame_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
